nfc_command_dispatcher: RTL and testbench
=========================================

// Module: nfc_command_dispatcher
// PURPOSE
//  Shares one Atomic Command Generator (ACG) port among NumOfCmds command modules (SetFeature, Reset, ReadID, ...).
//  A module's start pulse claims the ACG; its ACG request/write-data outputs are muxed through until its last-step pulse.
//  Sits between the command-module bank and the ACG; also gates write-ready, aggregates CMD-ready and runs a watchdog.
// PARAMETERS
//  NumberOfWays   4        way-select width
//  NumOfCmds      4        command modules sharing the ACG (1..8)
//  TimeoutCycles  1048576  max owner cycles w/o last-step before forced release (>=4, counter 21 bits)
// PORTS
//  iSystemClock        in   1           clock
//  iReset              in   1           sync, active-high reset
//  iStart              in   N           per-module start pulse (module k = bit k)
//  iLastStep           in   N           per-module last-step pulse
//  iCMDReady           in   N           per-module CMD ready
//  iCmd_Command        in   N*8         module k ACG command at [8k+7:8k]; same packing below
//  iCmd_CommandOption  in   N*3         module command option
//  iCmd_TargetWay      in   N*Ways      module target way
//  iCmd_NumOfData      in   N*16        module data count
//  iCmd_CASelect       in   N           module CA select
//  iCmd_CAData         in   N*40        module CA data
//  iCmd_WriteData      in   N*16        module write data
//  iCmd_WriteLast      in   N           module write last
//  iCmd_WriteValid     in   N           module write valid
//  oCmd_WriteReady     out  N           iACG_WriteReady routed to owner only
//  oACG_Command        out  8           muxed; same for the 7 following ACG outputs
//  oACG_CommandOption  out  3
//  oACG_TargetWay      out  Ways
//  oACG_NumOfData      out  16
//  oACG_CASelect       out  1
//  oACG_CAData         out  40
//  oACG_WriteData      out  16
//  oACG_WriteLast / oACG_WriteValid  out 1 each
//  iACG_WriteReady     in   1           ACG write ready
//  oCMDReady           out  1           IDLE and all iCMDReady set
//  oBusy               out  1           state != IDLE
//  oOwner              out  3           index of current owner
//  oConflict           out  1           1-cycle pulse: start lost/ignored
//  oTimeout            out  1           1-cycle pulse: watchdog release
// BEHAVIOUR
//  - States IDLE -> GRANT -> BUSY -> RELEASE -> IDLE; state, owner, counter, pulse outputs registered.
//  - Reset: state IDLE, owner 0, counter 0, oConflict=oTimeout=0, oBusy=0.
//  - Idle value (IDLE, GRANT, RELEASE): ACG command 0, option 0, target way 0, numofdata 0,
//    CASelect 1, CAData 0, write data 0, WriteLast 0, WriteValid 0, oCmd_WriteReady 0.
//  - IDLE: any iStart bit -> owner <= lowest set index, go GRANT; >1 bit set -> oConflict next cycle.
//  - GRANT: 1 cycle, idle values driven (covers module CMDLatch); -> BUSY.
//  - BUSY: all ACG outputs = owner's slice (comb mux from owner reg, 0 latency);
//    oCmd_WriteReady = iACG_WriteReady one-hot on owner.
//  - BUSY exit: iLastStep[owner] -> RELEASE; non-owner last-steps ignored.
//  - Watchdog: counter clears on GRANT, +1 per BUSY cycle; reaching TimeoutCycles-1 without last-step ->
//    RELEASE, oTimeout pulse; simultaneous last-step wins (no oTimeout).
//  - RELEASE: 1 cycle, idle values; -> IDLE. New start seen only from IDLE.
//  - iStart in GRANT/BUSY/RELEASE: ignored, oConflict pulses next cycle (modules must wait oCMDReady).
//  - Owner index >= NumOfCmds impossible; mux default = idle values.
//  - iReset mid-BUSY: next cycle IDLE, idle values, no oTimeout.
// TESTING
//  - N=4: iStart=4'b0100 -> oOwner=2, GRANT 1 cycle, then oACG_CAData=module2 40'hef_00_00_00_00, oBusy=1.
//  - iStart=4'b0110 same cycle -> owner 1, oConflict 1-cycle pulse; module2 slice never on ACG.
//  - BUSY owner 0, iACG_WriteReady=1 -> oCmd_WriteReady=4'b0001; iLastStep=4'b0010 ignored.
//  - iLastStep[owner] -> RELEASE 1 cycle (oACG_Command=0) -> IDLE, oCMDReady=1 when iCMDReady=4'hF.
//  - TimeoutCycles=16, no last-step -> oTimeout after 16 BUSY cycles, IDLE two cycles later.
//  - iReset asserted mid-BUSY -> next cycle oBusy=0, all ACG outputs idle values.

Source files
------------

// File: rtl/nfc_command_dispatcher.sv
// Arbitrates one Atomic Command Generator port among several NFC command modules.
// A start pulse claims the port. The owner's signals then pass through until its last step or a watchdog release.
module nfc_command_dispatcher #(
   parameter int NumberOfWays  = 4,
   parameter int NumOfCmds     = 4,
   parameter int TimeoutCycles = 1048576
) (
   input  logic                          iSystemClock,
   input  logic                          iReset,
   input  logic [NumOfCmds-1:0]          iStart,
   input  logic [NumOfCmds-1:0]          iLastStep,
   input  logic [NumOfCmds-1:0]          iCMDReady,
   input  logic [NumOfCmds*8-1:0]        iCmd_Command,
   input  logic [NumOfCmds*3-1:0]        iCmd_CommandOption,
   input  logic [NumOfCmds*NumberOfWays-1:0] iCmd_TargetWay,
   input  logic [NumOfCmds*16-1:0]       iCmd_NumOfData,
   input  logic [NumOfCmds-1:0]          iCmd_CASelect,
   input  logic [NumOfCmds*40-1:0]       iCmd_CAData,
   input  logic [NumOfCmds*16-1:0]       iCmd_WriteData,
   input  logic [NumOfCmds-1:0]          iCmd_WriteLast,
   input  logic [NumOfCmds-1:0]          iCmd_WriteValid,
   output logic [NumOfCmds-1:0]          oCmd_WriteReady,
   output logic [7:0]                    oACG_Command,
   output logic [2:0]                    oACG_CommandOption,
   output logic [NumberOfWays-1:0]       oACG_TargetWay,
   output logic [15:0]                   oACG_NumOfData,
   output logic                          oACG_CASelect,
   output logic [39:0]                   oACG_CAData,
   output logic [15:0]                   oACG_WriteData,
   output logic                          oACG_WriteLast,
   output logic                          oACG_WriteValid,
   input  logic                          iACG_WriteReady,
   output logic                          oCMDReady,
   output logic                          oBusy,
   output logic [2:0]                    oOwner,
   output logic                          oConflict,
   output logic                          oTimeout
);

   typedef enum logic [1:0] {StIdle, StGrant, StBusy, StRelease} state_t;

   localparam logic [20:0] TimeoutLast = 21'(TimeoutCycles - 1);

   state_t      state_q;
   logic [2:0]  owner_q;
   logic [20:0] watchdog_q;
   logic        conflict_q;
   logic        timeout_q;

   logic [2:0]  startOwner;
   logic [3:0]  startCount;
   logic        ownerLast;

   // The lowest requesting index wins. The request count is used to detect simultaneous claims.
   always_comb begin
      startOwner = '0;
      startCount = '0;
      ownerLast  = 1'b0;
      for (int k = NumOfCmds - 1; k >= 0; k--) begin
         if (iStart[k]) startOwner = 3'(k);
         startCount = startCount + 4'(iStart[k]);
         if (owner_q == 3'(k)) ownerLast = iLastStep[k];
      end
   end

   // GRANT and RELEASE are single guard cycles around the owner's tenure.
   // Any start outside IDLE is dropped and flagged.
   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         watchdog_q <= '0;
         conflict_q <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q  <= 1'b0;
         conflict_q <= |iStart;
         case (state_q)
            StIdle: begin
               conflict_q <= (startCount > 4'd1);
               if (|iStart) begin
                  owner_q <= startOwner;
                  state_q <= StGrant;
               end
            end
            StGrant: begin
               watchdog_q <= '0;
               state_q    <= StBusy;
            end
            StBusy: begin
               if (ownerLast) begin
                  state_q <= StRelease;
               end else if (watchdog_q == TimeoutLast) begin
                  state_q   <= StRelease;
                  timeout_q <= 1'b1;
               end else begin
                  watchdog_q <= watchdog_q + 21'd1;
               end
            end
            StRelease: state_q <= StIdle;
            default:   state_q <= StIdle;
         endcase
      end
   end

   // Only the owner's signals reach the ACG, and only while BUSY. Every other case drives idle values.
   always_comb begin
      oACG_Command       = '0;
      oACG_CommandOption = '0;
      oACG_TargetWay     = '0;
      oACG_NumOfData     = '0;
      oACG_CASelect      = 1'b1;
      oACG_CAData        = '0;
      oACG_WriteData     = '0;
      oACG_WriteLast     = 1'b0;
      oACG_WriteValid    = 1'b0;
      oCmd_WriteReady    = '0;
      for (int k = 0; k < NumOfCmds; k++) begin
         if (state_q == StBusy && owner_q == 3'(k)) begin
            oACG_Command       = iCmd_Command[8*k +: 8];
            oACG_CommandOption = iCmd_CommandOption[3*k +: 3];
            oACG_TargetWay     = iCmd_TargetWay[NumberOfWays*k +: NumberOfWays];
            oACG_NumOfData     = iCmd_NumOfData[16*k +: 16];
            oACG_CASelect      = iCmd_CASelect[k];
            oACG_CAData        = iCmd_CAData[40*k +: 40];
            oACG_WriteData     = iCmd_WriteData[16*k +: 16];
            oACG_WriteLast     = iCmd_WriteLast[k];
            oACG_WriteValid    = iCmd_WriteValid[k];
            oCmd_WriteReady[k] = iACG_WriteReady;
         end
      end
   end

   assign oBusy     = (state_q != StIdle);
   assign oCMDReady = (state_q == StIdle) && (&iCMDReady);
   assign oOwner    = owner_q;
   assign oConflict = conflict_q;
   assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_nfc_command_dispatcher.sv
// Randomized bench for nfc_command_dispatcher.
// It checks the DUT every cycle against a session-age reference model, with a few directed scenarios first.
module tb_nfc_command_dispatcher;

   localparam int N  = 4;
   localparam int W  = 4;
   localparam int TO = 16;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic          reset;
   logic [N-1:0]  start, lastStep, cmdReady, caSel, wLast, wValid;
   logic          acgWriteReady;
   logic [N*8-1:0]  pCommand;
   logic [N*3-1:0]  pOption;
   logic [N*W-1:0]  pWay;
   logic [N*16-1:0] pNum, pWData;
   logic [N*40-1:0] pCAData;

   logic [N-1:0]  oCmdWriteReady;
   logic [7:0]    oCommand;
   logic [2:0]    oOption;
   logic [W-1:0]  oWay;
   logic [15:0]   oNum, oWData;
   logic          oCASel, oWLast, oWValid;
   logic [39:0]   oCAData;
   logic          oCMDReady, oBusy, oConflict, oTimeout;
   logic [2:0]    oOwner;

   logic [7:0]   mCommand [N];
   logic [2:0]   mOption  [N];
   logic [W-1:0] mWay     [N];
   logic [15:0]  mNum     [N];
   logic [15:0]  mWData   [N];
   logic [39:0]  mCAData  [N];

   int checks = 0;
   int errors = 0;

   // Session-based reference: age counts cycles since a start was accepted (-1 = idle).
   // endAge is the age at which the single release cycle occurs (-1 = not yet decided).
   int mAge = -1;
   int mEnd = -1;
   int mOwner = 0;
   bit mConflict = 0;
   bit mTimeout = 0;

   nfc_command_dispatcher #(.NumberOfWays(W), .NumOfCmds(N), .TimeoutCycles(TO)) dut (
      .iSystemClock(clock), .iReset(reset), .iStart(start), .iLastStep(lastStep),
      .iCMDReady(cmdReady), .iCmd_Command(pCommand), .iCmd_CommandOption(pOption),
      .iCmd_TargetWay(pWay), .iCmd_NumOfData(pNum), .iCmd_CASelect(caSel),
      .iCmd_CAData(pCAData), .iCmd_WriteData(pWData), .iCmd_WriteLast(wLast),
      .iCmd_WriteValid(wValid), .oCmd_WriteReady(oCmdWriteReady), .oACG_Command(oCommand),
      .oACG_CommandOption(oOption), .oACG_TargetWay(oWay), .oACG_NumOfData(oNum),
      .oACG_CASelect(oCASel), .oACG_CAData(oCAData), .oACG_WriteData(oWData),
      .oACG_WriteLast(oWLast), .oACG_WriteValid(oWValid), .iACG_WriteReady(acgWriteReady),
      .oCMDReady(oCMDReady), .oBusy(oBusy), .oOwner(oOwner), .oConflict(oConflict),
      .oTimeout(oTimeout)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic packPayload();
      for (int k = 0; k < N; k++) begin
         pCommand[8*k +: 8] = mCommand[k];
         pOption[3*k +: 3]  = mOption[k];
         pWay[W*k +: W]     = mWay[k];
         pNum[16*k +: 16]   = mNum[k];
         pWData[16*k +: 16] = mWData[k];
         pCAData[40*k +: 40] = mCAData[k];
      end
   endtask

   task automatic randomPayload();
      for (int k = 0; k < N; k++) begin
         mCommand[k] = 8'($urandom);
         mOption[k]  = 3'($urandom);
         mWay[k]     = W'($urandom);
         mNum[k]     = 16'($urandom);
         mWData[k]   = 16'($urandom);
         mCAData[k]  = {8'($urandom), 32'($urandom)};
      end
      caSel  = N'($urandom);
      wLast  = N'($urandom);
      wValid = N'($urandom);
      packPayload();
   endtask

   // Advance the reference by one clock edge using the inputs that were present at that edge.
   task automatic modelUpdate();
      int lowest;
      if (reset) begin
         mAge = -1; mEnd = -1; mOwner = 0; mConflict = 0; mTimeout = 0;
         return;
      end
      mTimeout = 0;
      if (mAge < 0) begin
         mConflict = ($countones(start) > 1);
         if (start != 0) begin
            lowest = N;
            for (int k = N - 1; k >= 0; k--) if (start[k]) lowest = k;
            mOwner = lowest;
            mAge = 0;
            mEnd = -1;
         end
      end else begin
         mConflict = (start != 0);
         if (mEnd < 0 && mAge >= 1) begin
            if (lastStep[mOwner]) mEnd = mAge + 1;
            else if (mAge == TO) begin mEnd = mAge + 1; mTimeout = 1; end
         end
         mAge++;
         if (mEnd >= 0 && mAge > mEnd) mAge = -1;
      end
   endtask

   task automatic checkAll();
      bit busyNow;
      busyNow = (mAge >= 1) && (mEnd < 0 || mAge < mEnd);
      checkOutput("busy",     64'(oBusy),     64'(mAge >= 0));
      checkOutput("owner",    64'(oOwner),    64'(mOwner));
      checkOutput("cmdReady", 64'(oCMDReady), 64'(mAge < 0 && cmdReady == '1));
      checkOutput("conflict", 64'(oConflict), 64'(mConflict));
      checkOutput("timeout",  64'(oTimeout),  64'(mTimeout));
      checkOutput("command",  64'(oCommand),  busyNow ? 64'(mCommand[mOwner]) : 64'd0);
      checkOutput("option",   64'(oOption),   busyNow ? 64'(mOption[mOwner])  : 64'd0);
      checkOutput("way",      64'(oWay),      busyNow ? 64'(mWay[mOwner])     : 64'd0);
      checkOutput("numData",  64'(oNum),      busyNow ? 64'(mNum[mOwner])     : 64'd0);
      checkOutput("caSelect", 64'(oCASel),    busyNow ? 64'(caSel[mOwner])    : 64'd1);
      checkOutput("caData",   64'(oCAData),   busyNow ? 64'(mCAData[mOwner])  : 64'd0);
      checkOutput("wData",    64'(oWData),    busyNow ? 64'(mWData[mOwner])   : 64'd0);
      checkOutput("wLast",    64'(oWLast),    busyNow ? 64'(wLast[mOwner])    : 64'd0);
      checkOutput("wValid",   64'(oWValid),   busyNow ? 64'(wValid[mOwner])   : 64'd0);
      checkOutput("wReady",   64'(oCmdWriteReady),
                  busyNow ? 64'(N'(acgWriteReady) << mOwner) : 64'd0);
   endtask

   // Drive one cycle's control inputs, check the settled outputs, then clock the DUT and the model.
   task automatic applyStimulus(input logic rst, input logic [N-1:0] st, input logic [N-1:0] ls,
                                input logic wr, input logic [N-1:0] rdy);
      reset = rst; start = st; lastStep = ls; acgWriteReady = wr; cmdReady = rdy;
      #1;
      checkAll();
      @(posedge clock);
      modelUpdate();
      #1;
   endtask

   initial begin
      randomPayload();
      reset = 1'b1; start = '0; lastStep = '0; acgWriteReady = 1'b0; cmdReady = '1;
      @(posedge clock);
      modelUpdate();
      #1;

      // Lone claim by module 2, with a recognisable CA payload.
      mCAData[2] = 40'hef_00_00_00_00;
      packPayload();
      applyStimulus(0, 4'b0100, 4'b0000, 1'b0, 4'hF);
      checkOutput("dirOwner2", 64'(oOwner), 64'd2);
      checkOutput("dirGrantCA", 64'(oCAData), 64'd0);
      applyStimulus(0, 4'b0000, 4'b0000, 1'b0, 4'hF);
      checkOutput("dirBusyCA", 64'(oCAData), 64'hef_00_00_00_00);
      applyStimulus(0, 4'b0000, 4'b0100, 1'b0, 4'hF);
      applyStimulus(0, 4'b0000, 4'b0000, 1'b0, 4'hF);
      applyStimulus(0, 4'b0000, 4'b0000, 1'b0, 4'hF);
      checkOutput("dirIdleReady", 64'(oCMDReady), 64'd1);

      // Simultaneous claim: module 1 wins, module 0 owns a later session with writeReady routed.
      applyStimulus(0, 4'b0110, 4'b0000, 1'b0, 4'hF);
      checkOutput("dirConflict", 64'(oConflict), 64'd1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'b0000, 1'b1, 4'hF);
      applyStimulus(0, 4'b0000, 4'b0010, 1'b1, 4'hF);
      applyStimulus(0, 4'b0000, 4'b0000, 1'b1, 4'hF);
      applyStimulus(0, 4'b0001, 4'b0000, 1'b1, 4'hF);
      applyStimulus(0, 4'b0000, 4'b0010, 1'b1, 4'hF);
      checkOutput("dirWReady", 64'(oCmdWriteReady), 64'b0001);

      // Watchdog: no owner last-step for well beyond the timeout.
      for (int i = 0; i < TO + 4; i++) applyStimulus(0, 4'b0000, 4'b0000, 1'b0, 4'hF);
      checkOutput("dirAfterTimeout", 64'(oBusy), 64'd0);

      // Reset in the middle of a session.
      applyStimulus(0, 4'b1000, 4'b0000, 1'b0, 4'hF);
      for (int i = 0; i < 4; i++) applyStimulus(0, 4'b0000, 4'b0000, 1'b1, 4'hF);
      applyStimulus(1, 4'b0000, 4'b0000, 1'b1, 4'hF);
      checkOutput("dirResetBusy", 64'(oBusy), 64'd0);
      checkOutput("dirResetCmd", 64'(oCommand), 64'd0);

      // Random traffic: occasional starts, rare last-steps so the watchdog also fires.
      for (int i = 0; i < 3000; i++) begin
         randomPayload();
         applyStimulus(($urandom_range(0, 199) == 0),
                       ($urandom_range(0, 3) == 0) ? N'($urandom) : '0,
                       ($urandom_range(0, 14) == 0) ? N'($urandom) : '0,
                       1'($urandom),
                       ($urandom_range(0, 1) == 0) ? '1 : N'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
